// File: rtl/mod_seq_pkg.sv
// Shared helpers for the multi-phase modulus counter: modulus decoding,
// reset-default moduli and active-phase clamping.
package mod_seq_pkg;

    localparam int MIN_ACT = 1;

    // A programmed modulus of 0 stands for the full 2**cnt_w range.
    function automatic int eff_mod(input int value, input int cnt_w);
        return (value == 0) ? (1 << cnt_w) : value;
    endfunction

    function automatic int def_mod(input int idx, input int mod_even, input int mod_odd);
        return ((idx % 2) != 0) ? mod_odd : mod_even;
    endfunction

    function automatic int clamp_act(input int act, input int num_ph);
        if (act < MIN_ACT) begin
            return MIN_ACT;
        end
        if (act > num_ph) begin
            return num_ph;
        end
        return act;
    endfunction

endpackage

// File: rtl/mod_seq_counter_if.sv
// Control/status bundle of the sequence counter: enable, configuration
// write ports and the count/phase/strobe outputs.
interface mod_seq_counter_if #(
    parameter int CNT_W = 4,
    parameter int PH_W  = 2
) ();
    logic             en;
    logic             cfg_we;
    logic [PH_W-1:0]  cfg_idx;
    logic [CNT_W:0]   cfg_mod;
    logic             act_we;
    logic [PH_W:0]    act_ph;
    logic [CNT_W-1:0] cnt;
    logic [PH_W-1:0]  phase;
    logic             tc;
    logic             seq_done;

    modport master (
        output en, cfg_we, cfg_idx, cfg_mod, act_we, act_ph,
        input  cnt, phase, tc, seq_done
    );

    modport slave (
        input  en, cfg_we, cfg_idx, cfg_mod, act_we, act_ph,
        output cnt, phase, tc, seq_done
    );
endinterface

// File: rtl/mod_seq_cfg.sv
// Per-phase modulus register file and active-phase-count register; presents
// the decoded modulus of the current phase and the clamped active count.
module mod_seq_cfg
    import mod_seq_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int NUM_PH       = 4,
    parameter int PH_W         = (NUM_PH > 1) ? $clog2(NUM_PH) : 1,
    parameter int DEF_MOD_EVEN = 4,
    parameter int DEF_MOD_ODD  = 6,
    parameter int DEF_ACT_PH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cfg_we,
    input  logic [PH_W-1:0] i_cfg_idx,
    input  logic [CNT_W:0]  i_cfg_mod,
    input  logic            i_act_we,
    input  logic [PH_W:0]   i_act_ph,
    input  logic [PH_W-1:0] i_phase,
    output logic [CNT_W:0]  o_eff_mod,
    output logic [PH_W:0]   o_eff_act
);

    logic [CNT_W:0] r_mod [NUM_PH];
    logic [PH_W:0]  r_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PH; p++) begin
                r_mod[p] <= (CNT_W+1)'(def_mod(p, DEF_MOD_EVEN, DEF_MOD_ODD));
            end
            r_act <= (PH_W+1)'(DEF_ACT_PH);
        end else begin
            // Slot indices beyond the implemented phases are ignored.
            if (i_cfg_we && (int'(i_cfg_idx) < NUM_PH)) begin
                r_mod[i_cfg_idx] <= i_cfg_mod;
            end
            if (i_act_we) begin
                r_act <= i_act_ph;
            end
        end
    end

    assign o_eff_mod = (CNT_W+1)'(eff_mod(int'(r_mod[i_phase]), CNT_W));
    assign o_eff_act = (PH_W+1)'(clamp_act(int'(r_act), NUM_PH));

endmodule

// File: rtl/mod_seq_counter.sv
// Multi-phase modulus counter: counts 0..mod[p]-1 in each active phase,
// advancing phases and wrapping after the last one, with tc/seq_done strobes.
module mod_seq_counter
    import mod_seq_pkg::*;
#(
    parameter int CNT_W        = 4,
    parameter int NUM_PH       = 4,
    parameter int PH_W         = (NUM_PH > 1) ? $clog2(NUM_PH) : 1,
    parameter int DEF_MOD_EVEN = 4,
    parameter int DEF_MOD_ODD  = 6,
    parameter int DEF_ACT_PH   = 2
) (
    input logic               clk,
    input logic               rst,
    mod_seq_counter_if.slave  bus
);

    localparam logic [CNT_W:0]   MOD_ONE = (CNT_W+1)'(1);
    localparam logic [PH_W:0]    ACT_ONE = (PH_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);
    localparam logic [PH_W-1:0]  PH_INC  = PH_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W:0]   w_eff_mod;
    logic [PH_W:0]    w_eff_act;
    logic             w_term;
    logic             w_last;
    logic             w_tc;

    mod_seq_cfg #(
        .CNT_W        (CNT_W),
        .NUM_PH       (NUM_PH),
        .PH_W         (PH_W),
        .DEF_MOD_EVEN (DEF_MOD_EVEN),
        .DEF_MOD_ODD  (DEF_MOD_ODD),
        .DEF_ACT_PH   (DEF_ACT_PH)
    ) u_cfg (
        .clk       (clk),
        .rst       (rst),
        .i_cfg_we  (bus.cfg_we),
        .i_cfg_idx (bus.cfg_idx),
        .i_cfg_mod (bus.cfg_mod),
        .i_act_we  (bus.act_we),
        .i_act_ph  (bus.act_ph),
        .i_phase   (r_phase),
        .o_eff_mod (w_eff_mod),
        .o_eff_act (w_eff_act)
    );

    // >= rather than == so a modulus or active count shrunk below the current
    // position still terminates on the next enabled cycle.
    assign w_term = ({1'b0, r_cnt} >= (w_eff_mod - MOD_ONE));
    assign w_last = ({1'b0, r_phase} >= (w_eff_act - ACT_ONE));
    assign w_tc   = bus.en & w_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= '0;
        end else if (bus.en) begin
            if (w_term) begin
                r_cnt   <= '0;
                r_phase <= w_last ? '0 : (r_phase + PH_INC);
            end else begin
                r_cnt   <= r_cnt + CNT_INC;
            end
        end
    end

    assign bus.cnt      = r_cnt;
    assign bus.phase    = r_phase;
    assign bus.tc       = w_tc;
    assign bus.seq_done = w_tc & w_last;

endmodule

// File: tb/tb_mod_seq_counter.sv
// Self-checking bench for mod_seq_counter: directed scenarios plus a random
// run, all compared against a phase/count reference model held in plain ints.
module tb_mod_seq_counter;

    localparam int CNT_W  = 4;
    localparam int NUM_PH = 4;
    localparam int PH_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mod_seq_counter_if #(.CNT_W(CNT_W), .PH_W(PH_W)) bus ();

    mod_seq_counter #(
        .CNT_W (CNT_W), .NUM_PH (NUM_PH), .PH_W (PH_W),
        .DEF_MOD_EVEN (4), .DEF_MOD_ODD (6), .DEF_ACT_PH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_mod [NUM_PH];
    int m_act;
    int m_cnt;
    int m_ph;

    function automatic void model_reset();
        for (int p = 0; p < NUM_PH; p++) m_mod[p] = (p % 2 == 0) ? 4 : 6;
        m_act = 2;
        m_cnt = 0;
        m_ph  = 0;
    endfunction

    function automatic int m_len();
        return (m_mod[m_ph] == 0) ? (1 << CNT_W) : m_mod[m_ph];
    endfunction

    function automatic int m_nph();
        if (m_act < 1) return 1;
        if (m_act > NUM_PH) return NUM_PH;
        return m_act;
    endfunction

    function automatic bit exp_tc();
        return bus.en && (m_cnt >= m_len() - 1);
    endfunction

    function automatic bit exp_sd();
        return exp_tc() && (m_ph >= m_nph() - 1);
    endfunction

    // Applies one rising edge to the model using the inputs currently driven.
    function automatic void model_edge();
        bit done_phase;
        bit done_seq;
        done_phase = (m_cnt >= m_len() - 1);
        done_seq   = (m_ph >= m_nph() - 1);
        if (bus.en) begin
            if (done_phase) begin
                m_cnt = 0;
                m_ph  = done_seq ? 0 : m_ph + 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (bus.cfg_we) m_mod[bus.cfg_idx] = int'(bus.cfg_mod);
        if (bus.act_we) m_act = int'(bus.act_ph);
    endfunction

    task automatic set_in(input bit en, input bit cwe, input int idx, input int cmod,
                          input bit awe, input int act);
        bus.en      = en;
        bus.cfg_we  = cwe;
        bus.cfg_idx = PH_W'(idx);
        bus.cfg_mod = (CNT_W+1)'(cmod);
        bus.act_we  = awe;
        bus.act_ph  = (PH_W+1)'(act);
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int exp_c [20] = '{0,1,2,3,0,1,2,3,4,5,0,1,2,3,0,1,2,3,4,5};
        int ep;
        bit et, es;
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.cnt !== '0 || bus.phase !== '0 || bus.tc !== 1'b0 || bus.seq_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cnt/ph/tc/sd got %0d/%0d/%b/%b want 0/0/0/0",
                     bus.cnt, bus.phase, bus.tc, bus.seq_done);
        end
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ep = ((i % 10) < 4) ? 0 : 1;
            et = (ep == 0) ? (exp_c[i] == 3) : (exp_c[i] == 5);
            es = (ep == 1) && (exp_c[i] == 5);
            n_tests++;
            if (bus.cnt !== CNT_W'(exp_c[i]) || bus.phase !== PH_W'(ep) ||
                bus.tc !== et || bus.seq_done !== es) begin
                n_fail++;
                $display("FAIL default_seq[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, exp_c[i], ep, et, es);
            end
            advance();
        end
    endtask

    task automatic test_program();
        int first_sd = -1;
        apply_reset();
        set_in(1'b0, 1'b1, 2, 2, 1'b0, 0);
        advance();
        set_in(1'b0, 1'b1, 0, 0, 1'b1, 3);
        advance();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.seq_done === 1'b1 && first_sd < 0) first_sd = i;
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL program[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
            advance();
        end
        n_tests++;
        if (first_sd != 23) begin
            n_fail++;
            $display("FAIL program_seq_done_cycle: got %0d want 23", first_sd);
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        repeat (6) advance();
        set_in(1'b0, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(2) || bus.phase !== PH_W'(1) ||
                bus.tc !== 1'b0 || bus.seq_done !== 1'b0) begin
                n_fail++;
                $display("FAIL en_hold[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want 2/1/0/0",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done);
            end
            advance();
        end
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        advance();
        @(negedge clk);
        n_tests++;
        if (bus.cnt !== CNT_W'(3) || bus.phase !== PH_W'(1) || bus.cnt !== CNT_W'(m_cnt)) begin
            n_fail++;
            $display("FAIL en_resume: cnt/ph got %0d/%0d want 3/1", bus.cnt, bus.phase);
        end
    endtask

    task automatic test_mod_write();
        // Shrink the modulus of the running phase below the current count.
        apply_reset();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        repeat (8) advance();
        set_in(1'b0, 1'b1, 1, 3, 1'b0, 0);
        advance();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.cnt !== CNT_W'(4) || bus.phase !== PH_W'(1) || bus.tc !== 1'b1) begin
            n_fail++;
            $display("FAIL shrink_term: cnt/ph/tc got %0d/%0d/%b want 4/1/1", bus.cnt, bus.phase, bus.tc);
        end
        for (int i = 0; i < 10; i++) begin
            advance();
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL shrink_run[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
        end
        // A write landing on the terminal cycle uses the old modulus.
        advance();
        apply_reset();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        repeat (9) advance();
        set_in(1'b1, 1'b1, 1, 3, 1'b0, 0);
        @(negedge clk);
        n_tests++;
        if (bus.cnt !== CNT_W'(5) || bus.tc !== 1'b1 || bus.seq_done !== 1'b1) begin
            n_fail++;
            $display("FAIL write_at_tc: cnt/tc/sd got %0d/%b/%b want 5/1/1", bus.cnt, bus.tc, bus.seq_done);
        end
        advance();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL write_at_tc_run[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
            advance();
        end
    endtask

    task automatic test_mod_one_and_clamp();
        apply_reset();
        set_in(1'b0, 1'b1, 0, 1, 1'b1, 1);
        advance();
        for (int i = 0; i < 10; i++) begin
            // Halfway through, program act=0 which must clamp to 1.
            set_in(1'b1, 1'b0, 0, 0, (i == 4), 0);
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== '0 || bus.phase !== '0 || bus.tc !== 1'b1 || bus.seq_done !== 1'b1) begin
                n_fail++;
                $display("FAIL mod_one[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want 0/0/1/1",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done);
            end
            advance();
        end
        set_in(1'b1, 1'b0, 0, 0, 1'b1, NUM_PH + 1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL clamp_hi[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
            advance();
            set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        set_in(1'b0, 1'b1, 1, 9, 1'b1, 3);
        advance();
        set_in(1'b1, 1'b0, 0, 0, 1'b0, 0);
        repeat (8) advance();
        n_tests++;
        if (bus.cnt !== CNT_W'(4) || bus.phase !== PH_W'(1)) begin
            n_fail++;
            $display("FAIL pre_async: cnt/ph got %0d/%0d want 4/1", bus.cnt, bus.phase);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.cnt !== '0 || bus.phase !== '0) begin
            n_fail++;
            $display("FAIL async_reset: cnt/ph got %0d/%0d want 0/0", bus.cnt, bus.phase);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL post_async[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
            advance();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                   int'($urandom_range(0, NUM_PH - 1)), int'($urandom_range(0, 1 << CNT_W)),
                   $urandom_range(0, 14) == 0, int'($urandom_range(0, 2 * NUM_PH - 1)));
            @(negedge clk);
            n_tests++;
            if (bus.cnt !== CNT_W'(m_cnt) || bus.phase !== PH_W'(m_ph) ||
                bus.tc !== exp_tc() || bus.seq_done !== exp_sd()) begin
                n_fail++;
                $display("FAIL random[%0d]: cnt/ph/tc/sd got %0d/%0d/%b/%b want %0d/%0d/%b/%b",
                         i, bus.cnt, bus.phase, bus.tc, bus.seq_done, m_cnt, m_ph, exp_tc(), exp_sd());
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        set_in(1'b0, 1'b0, 0, 0, 1'b0, 0);
        @(posedge clk);
        #1;
        test_reset();
        test_program();
        advance();
        test_enable_hold();
        advance();
        test_mod_write();
        advance();
        test_mod_one_and_clamp();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod_seq_counter.md
Name: mod_seq_counter

Overview:
- Parametrised multi-phase modulus counter: steps through up to NUM_PH phases, each counting 0..MOD[p]-1, then advances to the next phase and wraps after the last active phase.
- Generalises the fixed 4/6 sandwich counter with:
  - runtime-programmable per-phase moduli and active phase count;
  - a count-enable input;
  - terminal-count and sequence-done strobes.
- Used as a sequencing/timing source for frame, burst and slot generators in the same clock domain.

Parameters:
- CNT_W, 4, width of the count value; maximum modulus 2**CNT_W.
- NUM_PH, 4, number of phase slots implemented (>=1).
- PH_W, $clog2(NUM_PH) (min 1), width of phase index.
- DEF_MOD_EVEN, 4, reset modulus for even-indexed phases.
- DEF_MOD_ODD, 6, reset modulus for odd-indexed phases.
- DEF_ACT_PH, 2, reset value of active phase count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  count enable; counter and phase hold when low.
- cfg_we  in  1  write strobe for a phase modulus.
- cfg_idx  in  PH_W  phase slot written by cfg_we.
- cfg_mod  in  CNT_W+1  modulus value written; 0 is treated as 2**CNT_W.
- act_we  in  1  write strobe for active phase count.
- act_ph  in  PH_W+1  active phase count written.
- cnt  out  CNT_W  current count.
- phase  out  PH_W  current phase index.
- tc  out  1  terminal count of current phase (combinational from registers).
- seq_done  out  1  tc asserted in last active phase.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - cnt=0, phase=0;
  - mod[p]=DEF_MOD_EVEN for even p, DEF_MOD_ODD for odd p;
  - act register=DEF_ACT_PH;
  - tc and seq_done follow from these values (both 0 unless the reset mod[0] is 1).
- Effective values:
  - eff_mod = (mod[phase]==0) ? 2**CNT_W : mod[phase];
  - eff_act = clamp(act, 1, NUM_PH);
  - last = (phase >= eff_act-1).
- Terminal condition: term = (cnt >= eff_mod-1), using >= so shrinking a modulus mid-count never strands the counter.
- Outputs:
  - tc = en & term;
  - seq_done = tc & last.
- Per rising edge with en=1:
  - if term: cnt<=0, and phase<=last ? 0 : phase+1;
  - else: cnt<=cnt+1, phase unchanged.
- en=0: cnt and phase hold. tc and seq_done are 0.
- Latency: a change in cnt or phase is visible one cycle after the enabled edge. tc is valid in the same cycle as the cnt value it flags.
- Modulus 1: cnt stays 0 and tc is high on every enabled cycle of that phase.
- cfg_we: mod[cfg_idx] <= cfg_mod on the edge.
  - Same-cycle write and terminal evaluation use the OLD value.
  - The new value governs from the next cycle, including a write to the current phase.
- act_we: the act register updates on the edge; the new value affects `last` from the next cycle.
  - If phase >= new eff_act, the phase counts out its modulus, then wraps to 0.
- cfg_we and act_we in the same cycle: both take effect independently.
- cnt arithmetic is CNT_W bits. With eff_mod = 2**CNT_W, term is cnt==all-ones; no overflow path exists.
- Reset mid-operation: immediate return to reset values, including config registers.

Decomposition:
- Package mod_seq_pkg:
  - helper function eff_mod(value, CNT_W);
  - default-modulus function def_mod(idx) returning DEF_MOD_EVEN/ODD;
  - clamp function for the active phase count.
- Sub-module mod_seq_cfg: per-phase modulus register file plus active-count register, with reset defaults and write ports. It outputs eff_mod for the current phase and eff_act.
- The top level holds the cnt/phase datapath and the strobe logic.

Test Plan:
- Reset defaults, en=1 for 20 cycles -> cnt 0,1,2,3,0,1,2,3,4,5,0,1,2,3,0,1,2,3,4,5; phase 0 then 1; tc at cnt 3 and 5; seq_done at cnt 5 only.
- act_ph=3, mod[2]=2, mod[0]=0 (CNT_W=4) -> phase 0 counts 0..15, phase 1 counts 0..5, phase 2 counts 0..1; seq_done on phase 2 cnt 1, then phase 0.
- Toggle en low for 3 cycles at cnt=2, phase 1 -> cnt/phase hold at 2/1 with tc=0; resumes at 3 when en returns.
- While phase 1 cnt=4, write mod[1]=3 -> next cycle term true (4>=2), cnt 0, phase 0. A write coinciding with cnt=5 uses old mod 6 and wraps normally.
- mod[0]=1, act_ph=1 -> cnt stuck at 0, tc and seq_done high every enabled cycle. act_ph=0 and act_ph=NUM_PH+1 -> clamped to 1 and NUM_PH respectively.
- Assert rst asynchronously mid-phase (phase 1, cnt 4, modified config) -> cnt=0, phase=0, moduli restore 4/6, act=2, without waiting for a clock edge.
